// File: rtl/poly_eval_horner_if.sv
`default_nettype none
// ============================================================================
//  Module   : poly_eval_horner_if
//  Purpose  : Operand-entry / result bundle for the Horner polynomial
//             evaluator.
//  Signals  : Go          - load strobe (press = capture, release = advance)
//             DataIn      - coefficient or x value being entered
//             DataResult  - y mod 2^WIDTH of the last completed evaluation
//             ResultValid - DataResult / Overflow hold a completed result
//             Overflow    - some Horner step exceeded 2^WIDTH-1
//             Busy        - evaluation in progress
//             CoeffIndex  - slot awaiting load (0=a_N .. DEGREE=a_0, DEGREE+1=x)
//  Revision : 1.0 - initial release
// ============================================================================
interface poly_eval_horner_if #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 3
);
    localparam int c_KW = $clog2(DEGREE + 2);

    logic             Go;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] DataResult;
    logic             ResultValid;
    logic             Overflow;
    logic             Busy;
    logic [c_KW-1:0]  CoeffIndex;

    modport slave (
        input  Go, DataIn,
        output DataResult, ResultValid, Overflow, Busy, CoeffIndex
    );

    modport master (
        output Go, DataIn,
        input  DataResult, ResultValid, Overflow, Busy, CoeffIndex
    );
endinterface
`default_nettype wire

// File: rtl/poly_eval_horner.sv
`default_nettype none
// ============================================================================
//  Module   : poly_eval_horner
//  Purpose  : Generic-degree, generic-width unsigned polynomial evaluator
//             y = a_N*x^N + ... + a_0 using Horner's method, one fused
//             multiply-add per clock. Operands are entered one per Go
//             press/release, highest coefficient first, x last.
//  Ports    : Clock  - system clock, rising edge
//             Resetn - asynchronous active-low reset
//             bus    - poly_eval_horner_if.slave (Go, DataIn in;
//                      DataResult, ResultValid, Overflow, Busy,
//                      CoeffIndex out)
//  Revision : 1.0 - initial release
// ============================================================================
module poly_eval_horner #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 3
) (
    input  wire logic            Clock,
    input  wire logic            Resetn,
    poly_eval_horner_if.slave    bus
);
    localparam int c_KW    = $clog2(DEGREE + 2);
    localparam int c_NSLOT = DEGREE + 2;
    localparam int c_FW    = 2 * WIDTH + 1;

    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(DEGREE);      // slot of a_0
    localparam logic [c_KW-1:0] c_K_X    = c_KW'(DEGREE + 1);  // slot of x

    localparam logic [1:0] S_LOAD      = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
    localparam logic [1:0] S_COMPUTE   = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]       r_state;
    logic [c_KW-1:0]  r_k;                   // load slot pointer
    logic [c_KW-1:0]  r_j;                   // compute slot pointer (= DEGREE - i)
    logic [WIDTH-1:0] r_slot [0:c_NSLOT-1];  // slot k holds a_(DEGREE-k); last slot is x
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_ovf;

    logic [2*WIDTH-1:0] w_prod;
    logic [c_FW-1:0]    w_full;

    // Walking the slot pointer upward from 1 visits a_(N-1) down to a_0,
    // which is the same order as counting i from DEGREE-1 down to 0.
    assign w_prod = r_acc * r_slot[c_NSLOT-1];
    assign w_full = {1'b0, w_prod} + c_FW'(r_slot[r_j]);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_LOAD;
            r_k      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            for (int s = 0; s < c_NSLOT; s++) begin
                r_slot[s] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.Go) begin
                        r_slot[r_k] <= bus.DataIn;
                        r_state     <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    // Capture happened on the press; waiting here for release
                    // means a long press still loads exactly one value.
                    if (!bus.Go) begin
                        if (r_k == c_K_X) begin
                            r_acc   <= r_slot[0];
                            r_j     <= c_KW'(1);
                            r_ovf   <= 1'b0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_k     <= r_k + c_KW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_full[WIDTH-1:0];
                    if (|w_full[c_FW-1:WIDTH]) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_j == c_K_LAST) begin
                        r_result <= w_full[WIDTH-1:0];
                        r_valid  <= 1'b1;
                        r_k      <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_j <= r_j + c_KW'(1);
                    end
                end
                S_DONE: begin
                    // A press here is the first load of the next run.
                    if (bus.Go) begin
                        r_slot[0] <= bus.DataIn;
                        r_valid   <= 1'b0;
                        r_k       <= '0;
                        r_state   <= S_LOAD_WAIT;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.DataResult  = r_result;
    assign bus.ResultValid = r_valid;
    assign bus.Overflow    = r_ovf;
    assign bus.Busy        = (r_state == S_COMPUTE);
    assign bus.CoeffIndex  = ((r_state == S_LOAD) || (r_state == S_LOAD_WAIT)) ? r_k : '0;

endmodule
`default_nettype wire
